// File: rtl/idex_buffer_pkg.sv
// Shared widths and the ID/EX control bundle for the 16-bit pipeline.
// idex_ctrl_t is reused by the EX/MEM stage for its control fields.
package idex_buffer_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int FUNCT_W    = 4;
  localparam int ALUOP_W    = 2;

  typedef struct packed {
    logic               r15;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic [ALUOP_W-1:0] aluop;
  } idex_ctrl_t;

  localparam int CTRL_W = $bits(idex_ctrl_t);
  localparam int OPND_W = 3 * DATA_W;
  localparam int TAG_W  = FUNCT_W + 2 * REG_ADDR_W;

endpackage

// File: rtl/idex_buffer_pipe_reg.sv
// Generic pipeline register: async active-high reset to zero,
// synchronous clear (bubble), otherwise loads every cycle.
module pipe_reg
  import idex_buffer_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // stage flop: reset beats clear, clear beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (clr) begin
      q_r <= {W{1'b0}};
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/idex_buffer.sv
// ID/EX pipeline register: wiring of three pipe_reg field groups
// (control bundle, operands, function code plus source register tags).
module idex_buffer
  import idex_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_flush,
  input  logic [DATA_W-1:0]     rd1_in,
  input  logic [DATA_W-1:0]     rd2_in,
  input  logic [DATA_W-1:0]     sign_ext_in,
  input  logic [FUNCT_W-1:0]    funct_code_in,
  input  logic [REG_ADDR_W-1:0] rs_in,
  input  logic [REG_ADDR_W-1:0] rt_in,
  input  logic                  r15_in,
  input  logic                  alu_src_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  branch_in,
  input  logic [ALUOP_W-1:0]    aluop_in,
  output logic [DATA_W-1:0]     rd1_out,
  output logic [DATA_W-1:0]     rd2_out,
  output logic [DATA_W-1:0]     sign_ext_out,
  output logic [FUNCT_W-1:0]    funct_code_out,
  output logic [REG_ADDR_W-1:0] rs_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic                  r15_out,
  output logic                  alu_src_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  branch_out,
  output logic [ALUOP_W-1:0]    aluop_out
);

  idex_ctrl_t        ctrl_in_s;
  idex_ctrl_t        ctrl_out_s;
  logic [OPND_W-1:0] opnd_in_s;
  logic [OPND_W-1:0] opnd_out_s;
  logic [TAG_W-1:0]  tag_in_s;
  logic [TAG_W-1:0]  tag_out_s;

  assign ctrl_in_s = {r15_in, alu_src_in, mem_to_reg_in, reg_write_in,
                      mem_read_in, mem_write_in, branch_in, aluop_in};
  assign opnd_in_s = {rd1_in, rd2_in, sign_ext_in};
  assign tag_in_s  = {funct_code_in, rs_in, rt_in};

  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .clr (idex_flush),
    .d   (ctrl_in_s),
    .q   (ctrl_out_s)
  );

  pipe_reg #(.W(OPND_W)) u_opnd (
    .clk (clk),
    .rst (rst),
    .clr (idex_flush),
    .d   (opnd_in_s),
    .q   (opnd_out_s)
  );

  pipe_reg #(.W(TAG_W)) u_tag (
    .clk (clk),
    .rst (rst),
    .clr (idex_flush),
    .d   (tag_in_s),
    .q   (tag_out_s)
  );

  assign r15_out        = ctrl_out_s.r15;
  assign alu_src_out    = ctrl_out_s.alu_src;
  assign mem_to_reg_out = ctrl_out_s.mem_to_reg;
  assign reg_write_out  = ctrl_out_s.reg_write;
  assign mem_read_out   = ctrl_out_s.mem_read;
  assign mem_write_out  = ctrl_out_s.mem_write;
  assign branch_out     = ctrl_out_s.branch;
  assign aluop_out      = ctrl_out_s.aluop;

  assign {rd1_out, rd2_out, sign_ext_out}  = opnd_out_s;
  assign {funct_code_out, rs_out, rt_out}  = tag_out_s;

endmodule

// File: tb/tb_idex_buffer.sv
// Scoreboard bench for idex_buffer: expected stage contents are queued
// when inputs are driven and compared after the capturing edge.
module tb_idex_buffer;
  import idex_buffer_pkg::*;

  localparam int VW = 69;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  idex_flush;
  logic [DATA_W-1:0]     rd1_in, rd2_in, sign_ext_in;
  logic [FUNCT_W-1:0]    funct_code_in;
  logic [REG_ADDR_W-1:0] rs_in, rt_in;
  logic                  r15_in, alu_src_in, mem_to_reg_in, reg_write_in;
  logic                  mem_read_in, mem_write_in, branch_in;
  logic [ALUOP_W-1:0]    aluop_in;
  logic [DATA_W-1:0]     rd1_out, rd2_out, sign_ext_out;
  logic [FUNCT_W-1:0]    funct_code_out;
  logic [REG_ADDR_W-1:0] rs_out, rt_out;
  logic                  r15_out, alu_src_out, mem_to_reg_out, reg_write_out;
  logic                  mem_read_out, mem_write_out, branch_out;
  logic [ALUOP_W-1:0]    aluop_out;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] out_vec_s;
  int            total_cnt = 0;
  int            bad_cnt   = 0;

  idex_buffer dut (
    .clk(clk), .rst(rst), .idex_flush(idex_flush),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .sign_ext_in(sign_ext_in),
    .funct_code_in(funct_code_in), .rs_in(rs_in), .rt_in(rt_in),
    .r15_in(r15_in), .alu_src_in(alu_src_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .branch_in(branch_in), .aluop_in(aluop_in),
    .rd1_out(rd1_out), .rd2_out(rd2_out), .sign_ext_out(sign_ext_out),
    .funct_code_out(funct_code_out), .rs_out(rs_out), .rt_out(rt_out),
    .r15_out(r15_out), .alu_src_out(alu_src_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .branch_out(branch_out), .aluop_out(aluop_out)
  );

  always #5 clk = ~clk;

  assign out_vec_s = {rd1_out, rd2_out, sign_ext_out, funct_code_out, rs_out,
                      rt_out, r15_out, alu_src_out, mem_to_reg_out,
                      reg_write_out, mem_read_out, mem_write_out, branch_out,
                      aluop_out};

  function automatic logic [VW-1:0] in_vec();
    return {rd1_in, rd2_in, sign_ext_in, funct_code_in, rs_in, rt_in, r15_in,
            alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in,
            mem_write_in, branch_in, aluop_in};
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_ref_inputs();
    rd1_in = 16'h0003; rd2_in = 16'h0007; sign_ext_in = 16'h0008;
    rs_in = 4'd9; rt_in = 4'd4; funct_code_in = 4'b0010; aluop_in = 2'b11;
    r15_in = 1'b1; alu_src_in = 1'b0; mem_to_reg_in = 1'b1;
    reg_write_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
    branch_in = 1'b0;
  endtask

  task automatic set_rand_inputs();
    rd1_in = 16'($urandom); rd2_in = 16'($urandom);
    sign_ext_in = 16'($urandom); funct_code_in = 4'($urandom);
    rs_in = 4'($urandom); rt_in = 4'($urandom); aluop_in = 2'($urandom);
    {r15_in, alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in,
     mem_write_in, branch_in} = 7'($urandom);
  endtask

  // Called 1 time unit after a rising edge: queue expectation, cross edge, compare.
  task automatic step(input string tag, input logic flush);
    idex_flush = flush;
    exp_q.push_back((rst || flush) ? {VW{1'b0}} : in_vec());
    @(posedge clk);
    #1;
    check(tag, out_vec_s, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1;
    idex_flush = 1'b0;
    set_ref_inputs();
    @(posedge clk);
    #1;
    check("reset_state", out_vec_s, {VW{1'b0}});
    rst = 1'b0;

    step("normal_load", 1'b0);
    check("normal_load_const",
          {rd1_out, rd2_out, sign_ext_out, rs_out, rt_out, funct_code_out,
           aluop_out, r15_out, alu_src_out, mem_to_reg_out, reg_write_out,
           mem_read_out, mem_write_out, branch_out},
          69'({16'h0003, 16'h0007, 16'h0008, 4'd9, 4'd4, 4'b0010, 2'b11,
               7'b1011000}));
    step("flush", 1'b1);
    check("flush_enables", 69'({reg_write_out, mem_to_reg_out, rd1_out}),
          69'({1'b0, 1'b0, 16'h0000}));

    for (int i = 0; i < 4; i++) begin
      step($sformatf("recover_%0d", i), 1'(i % 2));
    end

    // latency: mid-cycle change must not reach the output before the edge
    step("latency_pre", 1'b0);
    rd1_in = 16'hBEEF;
    #2;
    check("latency_hold", 69'(rd1_out), 69'(16'h0003));
    step("latency_post", 1'b0);
    check("latency_beef", 69'(rd1_out), 69'(16'hBEEF));

    // flush pulse entirely between edges is ignored
    idex_flush = 1'b1;
    #2;
    idex_flush = 1'b0;
    #1;
    check("flush_glitch_hold", out_vec_s, in_vec());
    set_ref_inputs();
    step("flush_glitch_load", 1'b0);

    // asynchronous reset mid-cycle with nonzero outputs
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", out_vec_s, {VW{1'b0}});
    @(posedge clk);
    #1;
    step("reset_priority_0", 1'b0);
    step("reset_priority_1", 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("reset_release_hold", out_vec_s, {VW{1'b0}});
    @(posedge clk);
    #1;
    check("reset_release_load", out_vec_s, in_vec());

    for (int i = 0; i < 24; i++) begin
      set_rand_inputs();
      step($sformatf("rand_%0d", i), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/idex_buffer.md
Name: idex_buffer

Overview:
ID/EX pipeline register of the 16-bit pipelined processor. On each rising clock edge it captures decoded operands, immediate, function code, source register numbers and control bits from the decode stage, and presents them to the execute stage. A flush input inserts a bubble by clearing all captured fields; an asynchronous reset clears the whole stage.

Parameters:
DATA_W, 16, width of register-read data and sign-extended immediate
REG_ADDR_W, 4, width of source register numbers RS/RT
FUNCT_W, 4, width of ALU function code
ALUOP_W, 2, width of ALU operation class

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  reset, asynchronous, active-high
idex_flush  in  1  synchronous flush (bubble insert)
rd1_in  in  DATA_W  register file read data 1
rd2_in  in  DATA_W  register file read data 2
sign_ext_in  in  DATA_W  sign-extended immediate
funct_code_in  in  FUNCT_W  ALU function code
rs_in  in  REG_ADDR_W  source register number RS (from IF/ID)
rt_in  in  REG_ADDR_W  source register number RT (from IF/ID)
r15_in  in  1  R15 write/select control
alu_src_in  in  1  ALU B-operand select (1 = immediate)
mem_to_reg_in  in  1  writeback select (1 = memory data)
reg_write_in  in  1  register write enable
mem_read_in  in  1  data memory read enable
mem_write_in  in  1  data memory write enable
branch_in  in  1  branch instruction flag
aluop_in  in  ALUOP_W  ALU operation class
rd1_out, rd2_out, sign_ext_out, funct_code_out, rs_out, rt_out  out  same widths as inputs  registered copies
r15_out, alu_src_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, branch_out  out  1  registered control
aluop_out  out  ALUOP_W  registered ALU operation class

Behaviour:
- All outputs driven directly from flops; no combinational path input->output.
- rst=1 (asynchronous, any time): every output = 0 immediately; held 0 while rst=1.
- Rising clk, rst=0, idex_flush=1: every output register loaded with 0 (control and data alike) -> bubble; all write/memory enables deasserted.
- Rising clk, rst=0, idex_flush=0: every output register loads its corresponding input.
- Latency: exactly one cycle; value sampled at edge N visible after edge N until edge N+1.
- Priority: rst > idex_flush > load.
- Flush is level-sampled at the edge only; flush pulses between edges have no effect.
- Reset deassertion between edges: outputs stay 0 until next rising edge, which then loads (or flushes) normally.
- X/uninitialised inputs at a load edge propagate as-is; no sanitising.
- No stall/enable: buffer loads every non-reset cycle.

Decomposition:
- Shared package: DATA_W, REG_ADDR_W, FUNCT_W, ALUOP_W constants; optional packed struct of the seven control bits + aluop (idex_ctrl_t) reused by EX/MEM stage.
- One natural sub-module: pipe_reg (parameterised width, async active-high reset to 0, sync clear, load) instantiated per field group; top level is wiring only.

Test Plan:
- Reset: assert rst mid-cycle with outputs nonzero -> all outputs 0 without waiting for clk; release, next edge loads inputs.
- Normal load: flush=0, rd1=0x0003, rd2=0x0007, sign_ext=0x0008, rs=9, rt=4, funct=4'b0010, aluop=2'b11, r15=1, alu_src=0, mem_to_reg=1, reg_write=1, mem_read=0, mem_write=0, branch=0 -> after one edge outputs equal these values exactly.
- Flush: same inputs, flush=1 -> after edge all outputs 0 (reg_write_out=0, mem_to_reg_out=0, rd1_out=0).
- Recovery: flush alternating 0,1,0,1 every cycle with constant inputs -> outputs alternate between loaded values and all-zero on consecutive edges.
- Latency: change rd1 from 0x0003 to 0xBEEF between edges -> rd1_out unchanged until next rising edge, then 0xBEEF.
- Priority: rst=1 and flush=0 with valid inputs across edges -> outputs remain 0.
